voice_allocator: RTL and testbench

Converts note-on/note-off commands into voice-operator register writes for the FM pipeline. Tracks which of the 32 voices are sounding and picks a voice for each new note. Sequences the phase-step and NoteOn writes onto a valid/ready write port. The port is muxed with SPI host writes upstream of the register decode.

---
 rtl/voice_allocator.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: turns note-on/note-off commands into FM voice-operator
// register writes. Tracks which of NUM_VOICES voices are sounding, scans them
// one per cycle to pick a target, then sequences the off / phase-step / NoteOn
// writes onto a valid/ready write port.
//
// Optional feature macro: VOICE_STEAL_EN. When defined, a note-on that finds
// neither a matching nor a free voice steals the oldest voice (largest
// (seq - stamp) mod 2^16, lower index on tie). When undefined that note-on is
// dropped and the age tracking (stamps, sequence counter) is not built.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the source holds valid and its payload stable until then, and
// the sink may raise or lower ready at any time.
module voice_allocator #(
    parameter int NUM_VOICES    = 32,
    parameter int NUM_OPERATORS = 8
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_CmdValid,
    output logic                  o_CmdReady,
    input  logic                  i_CmdNoteOn,
    input  logic [6:0]            i_CmdKey,
    input  logic [15:0]           i_CmdPhaseStep,
    output logic                  o_WriteValid,
    input  logic                  i_WriteReady,
    output logic [14:0]           o_WriteNumber,
    output logic [15:0]           o_WriteValue,
    output logic [NUM_VOICES-1:0] o_VoiceActive,
    output logic                  o_Drop,
    output logic [2:0]            o_DbgState
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SCAN        = 3'd1,
        S_WRITE_OFF   = 3'd2,
        S_WRITE_PHASE = 3'd3,
        S_WRITE_ON    = 3'd4
    } state_t;

    localparam logic [5:0] SCAN_LAST = 6'(NUM_VOICES - 1);
    localparam logic [5:0] SCAN_TAIL = 6'(NUM_VOICES);
    localparam logic [2:0] OP_LAST   = 3'(NUM_OPERATORS - 1);

    state_t                state_q, state_d;
    logic [5:0]            scan_idx_q, scan_idx_d;
    logic                  cmd_on_q, cmd_on_d;
    logic [6:0]            cmd_key_q, cmd_key_d;
    logic [15:0]           cmd_step_q, cmd_step_d;
    logic                  match_found_q, match_found_d;
    logic [4:0]            match_idx_q, match_idx_d;
    logic                  free_found_q, free_found_d;
    logic [4:0]            free_idx_q, free_idx_d;
    logic [4:0]            tgt_q, tgt_d;
    logic [2:0]            op_q, op_d;
    logic                  drop_q, drop_d;
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [6:0]            key_q [NUM_VOICES];
    logic [6:0]            key_d [NUM_VOICES];

    // Scan results including the voice visited this cycle.
    logic [4:0]            cur_v;
    logic                  match_found_s, free_found_s;
    logic [4:0]            match_idx_s, free_idx_s;

`ifdef VOICE_STEAL_EN
    logic [15:0]           seq_q, seq_d;
    logic [15:0]           stamp_q [NUM_VOICES];
    logic [15:0]           stamp_d [NUM_VOICES];
    logic                  old_found_q, old_found_d;
    logic [4:0]            old_idx_q, old_idx_d;
    logic [15:0]           old_age_q, old_age_d;
    logic                  old_found_s;
    logic [4:0]            old_idx_s;
    logic [15:0]           old_age_s;
    logic [15:0]           cur_age;
`endif

    // Fold the currently visited voice into the running scan results.
    always_comb begin
        cur_v         = scan_idx_q[4:0];
        match_found_s = match_found_q;
        match_idx_s   = match_idx_q;
        free_found_s  = free_found_q;
        free_idx_s    = free_idx_q;
        if (!match_found_q && active_q[cur_v] && (key_q[cur_v] == cmd_key_q)) begin
            match_found_s = 1'b1;
            match_idx_s   = cur_v;
        end
        if (!free_found_q && !active_q[cur_v]) begin
            free_found_s = 1'b1;
            free_idx_s   = cur_v;
        end
`ifdef VOICE_STEAL_EN
        cur_age     = seq_q - stamp_q[cur_v];
        old_found_s = old_found_q;
        old_idx_s   = old_idx_q;
        old_age_s   = old_age_q;
        // Strict compare keeps the lower index on equal ages.
        if (active_q[cur_v] && (!old_found_q || (cur_age > old_age_q))) begin
            old_found_s = 1'b1;
            old_idx_s   = cur_v;
            old_age_s   = cur_age;
        end
`endif
    end

    // Next-state logic: command latch, scan bookkeeping, write sequencing.
    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        cmd_on_d      = cmd_on_q;
        cmd_key_d     = cmd_key_q;
        cmd_step_d    = cmd_step_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        tgt_d         = tgt_q;
        op_d          = op_q;
        drop_d        = 1'b0;
        active_d      = active_q;
        key_d         = key_q;
`ifdef VOICE_STEAL_EN
        seq_d         = seq_q;
        stamp_d       = stamp_q;
        old_found_d   = old_found_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_CmdValid) begin
                    cmd_on_d      = i_CmdNoteOn;
                    cmd_key_d     = i_CmdKey;
                    cmd_step_d    = i_CmdPhaseStep;
                    scan_idx_d    = 6'd0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
`ifdef VOICE_STEAL_EN
                    old_found_d   = 1'b0;
`endif
                    state_d       = S_SCAN;
                end
            end
            S_SCAN: begin
                if (scan_idx_q == SCAN_TAIL) begin
                    // Cycle in which the drop pulse is visible.
                    state_d = S_IDLE;
                end else begin
                    match_found_d = match_found_s;
                    match_idx_d   = match_idx_s;
                    free_found_d  = free_found_s;
                    free_idx_d    = free_idx_s;
`ifdef VOICE_STEAL_EN
                    old_found_d   = old_found_s;
                    old_idx_d     = old_idx_s;
                    old_age_d     = old_age_s;
`endif
                    scan_idx_d    = scan_idx_q + 6'd1;
                    if (scan_idx_q == SCAN_LAST) begin
                        op_d = 3'd0;
                        if (match_found_s) begin
                            tgt_d   = match_idx_s;
                            state_d = S_WRITE_OFF;
                        end else if (cmd_on_q && free_found_s) begin
                            tgt_d   = free_idx_s;
                            state_d = S_WRITE_PHASE;
`ifdef VOICE_STEAL_EN
                        end else if (cmd_on_q && old_found_s) begin
                            tgt_d   = old_idx_s;
                            state_d = S_WRITE_OFF;
`endif
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                end
            end
            S_WRITE_OFF: begin
                if (i_WriteReady) begin
                    if (cmd_on_q) begin
                        op_d    = 3'd0;
                        state_d = S_WRITE_PHASE;
                    end else begin
                        active_d[tgt_q] = 1'b0;
                        state_d         = S_IDLE;
                    end
                end
            end
            S_WRITE_PHASE: begin
                if (i_WriteReady) begin
                    if (op_q == OP_LAST) begin
                        state_d = S_WRITE_ON;
                    end else begin
                        op_d = op_q + 3'd1;
                    end
                end
            end
            S_WRITE_ON: begin
                if (i_WriteReady) begin
                    active_d[tgt_q] = 1'b1;
                    key_d[tgt_q]    = cmd_key_q;
`ifdef VOICE_STEAL_EN
                    stamp_d[tgt_q]  = seq_q;
                    seq_d           = seq_q + 16'd1;
`endif
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q       <= S_IDLE;
            scan_idx_q    <= 6'd0;
            cmd_on_q      <= 1'b0;
            cmd_key_q     <= 7'd0;
            cmd_step_q    <= 16'd0;
            match_found_q <= 1'b0;
            match_idx_q   <= 5'd0;
            free_found_q  <= 1'b0;
            free_idx_q    <= 5'd0;
            tgt_q         <= 5'd0;
            op_q          <= 3'd0;
            drop_q        <= 1'b0;
            active_q      <= '0;
            key_q         <= '{default: '0};
`ifdef VOICE_STEAL_EN
            seq_q         <= 16'd0;
            stamp_q       <= '{default: '0};
            old_found_q   <= 1'b0;
            old_idx_q     <= 5'd0;
            old_age_q     <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            scan_idx_q    <= scan_idx_d;
            cmd_on_q      <= cmd_on_d;
            cmd_key_q     <= cmd_key_d;
            cmd_step_q    <= cmd_step_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            tgt_q         <= tgt_d;
            op_q          <= op_d;
            drop_q        <= drop_d;
            active_q      <= active_d;
            key_q         <= key_d;
`ifdef VOICE_STEAL_EN
            seq_q         <= seq_d;
            stamp_q       <= stamp_d;
            old_found_q   <= old_found_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
`endif
        end
    end

    // Output decode; write payload depends only on state/target/op, so it
    // holds still while a write is stalled.
    always_comb begin
        o_CmdReady    = (state_q == S_IDLE);
        o_WriteValid  = 1'b0;
        o_WriteNumber = '0;
        o_WriteValue  = '0;
        case (state_q)
            S_WRITE_OFF: begin
                o_WriteValid  = 1'b1;
                o_WriteNumber = {1'b0, 6'h10, tgt_q, 3'b000};
                o_WriteValue  = 16'h0000;
            end
            S_WRITE_PHASE: begin
                o_WriteValid  = 1'b1;
                o_WriteNumber = {1'b0, 6'h00, tgt_q, op_q};
                o_WriteValue  = cmd_step_q;
            end
            S_WRITE_ON: begin
                o_WriteValid  = 1'b1;
                o_WriteNumber = {1'b0, 6'h10, tgt_q, 3'b000};
                o_WriteValue  = 16'h0001;
            end
            default: ;
        endcase
        o_VoiceActive = active_q;
        o_Drop        = drop_q;
        o_DbgState    = state_q;
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random commands, checked
// against a voice-table model that works from the allocation rules directly.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        i_Reset;
    logic        i_CmdValid;
    logic        o_CmdReady;
    logic        i_CmdNoteOn;
    logic [6:0]  i_CmdKey;
    logic [15:0] i_CmdPhaseStep;
    logic        o_WriteValid;
    logic        i_WriteReady;
    logic [14:0] o_WriteNumber;
    logic [15:0] o_WriteValue;
    logic [31:0] o_VoiceActive;
    logic        o_Drop;
    logic [2:0]  o_DbgState;

    voice_allocator dut (
        .i_Clock(clk), .i_Reset(i_Reset),
        .i_CmdValid(i_CmdValid), .o_CmdReady(o_CmdReady),
        .i_CmdNoteOn(i_CmdNoteOn), .i_CmdKey(i_CmdKey),
        .i_CmdPhaseStep(i_CmdPhaseStep),
        .o_WriteValid(o_WriteValid), .i_WriteReady(i_WriteReady),
        .o_WriteNumber(o_WriteNumber), .o_WriteValue(o_WriteValue),
        .o_VoiceActive(o_VoiceActive), .o_Drop(o_Drop),
        .o_DbgState(o_DbgState)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: voice table and expected write queue {number, value}
    logic [30:0] exp_q[$];
    logic [31:0] m_act;
    int          m_key[32];
    int          m_stamp[32];
    int          m_seq;
    bit          exp_drop;

    task automatic model_clear();
        m_act = '0;
        m_seq = 0;
        for (int i = 0; i < 32; i++) begin
            m_key[i]   = 0;
            m_stamp[i] = 0;
        end
        exp_q.delete();
    endtask

    function automatic logic [30:0] wr(input int num, input int val);
        logic [14:0] n;
        logic [15:0] v;
        n = 15'(num);
        v = 16'(val);
        return {n, v};
    endfunction

    task automatic model_cmd(input bit on, input int k, input int step);
        int match = -1;
        int free  = -1;
        int old   = -1;
        int oage  = -1;
        int tgt   = -1;
        int age;
        bit off   = 0;
        for (int i = 0; i < 32; i++) begin
            if (m_act[i] && m_key[i] == k && match < 0) match = i;
            if (!m_act[i] && free < 0) free = i;
            age = (m_seq - m_stamp[i]) & 16'hffff;
            if (m_act[i] && age > oage) begin
                old  = i;
                oage = age;
            end
        end
        exp_drop = 0;
        if (on) begin
            if (match >= 0) begin
                tgt = match; off = 1;
            end else if (free >= 0) begin
                tgt = free;
`ifdef VOICE_STEAL_EN
            end else begin
                tgt = old; off = 1;
`endif
            end
            if (tgt < 0) begin
                exp_drop = 1;
            end else begin
                if (off) exp_q.push_back(wr(16'h1000 + tgt * 8, 0));
                for (int op = 0; op < 8; op++) exp_q.push_back(wr(tgt * 8 + op, step));
                exp_q.push_back(wr(16'h1000 + tgt * 8, 1));
                m_act[tgt]   = 1'b1;
                m_key[tgt]   = k;
                m_stamp[tgt] = m_seq;
                m_seq        = (m_seq + 1) & 16'hffff;
            end
        end else begin
            if (match >= 0) begin
                exp_q.push_back(wr(16'h1000 + match * 8, 0));
                m_act[match] = 1'b0;
            end else begin
                exp_drop = 1;
            end
        end
    endtask

    // Write-ready driver: held high, or randomized per cycle
    bit rand_ready = 0;
    always @(posedge clk) begin
        #1;
        if (rand_ready) i_WriteReady = 1'($urandom_range(0, 1));
        else            i_WriteReady = 1'b1;
    end

    // Compare process: accepted writes against the model queue, stall stability
    int          wr_count;
    int          first_wr_cyc;
    int          drop_cnt;
    int          drop_cyc;
    bit          stall_prev = 0;
    logic [14:0] prev_num;
    logic [15:0] prev_val;
    logic [30:0] e;
    always @(negedge clk) begin
        if (!i_Reset) begin
            if (stall_prev) begin
                chk("stall_valid", {31'd0, o_WriteValid}, 32'd1);
                chk("stall_number", {17'd0, o_WriteNumber}, {17'd0, prev_num});
                chk("stall_value", {16'd0, o_WriteValue}, {16'd0, prev_val});
            end
            if (o_WriteValid && first_wr_cyc < 0) first_wr_cyc = cyc;
            if (o_WriteValid && i_WriteReady) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {17'd0, o_WriteNumber}, 32'hffffffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_number", {17'd0, o_WriteNumber}, {17'd0, e[30:16]});
                    chk("write_value", {16'd0, o_WriteValue}, {16'd0, e[15:0]});
                end
            end
            if (o_Drop) begin
                drop_cnt++;
                drop_cyc = cyc;
            end
            stall_prev = o_WriteValid && !i_WriteReady;
            prev_num   = o_WriteNumber;
            prev_val   = o_WriteValue;
        end else begin
            stall_prev = 0;
        end
    end

    // Driver tasks
    int t_acc;
    int lat;

    task automatic do_reset();
        i_Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_Reset = 1'b0;
        model_clear();
    endtask

    task automatic issue(input bit on, input int k, input int step);
        int n = 0;
        @(negedge clk);
        while (!o_CmdReady && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!o_CmdReady) chk("cmd_ready_timeout", 32'd0, 32'd1);
        wr_count     = 0;
        first_wr_cyc = -1;
        drop_cnt     = 0;
        drop_cyc     = -1;
        i_CmdValid     = 1'b1;
        i_CmdNoteOn    = on;
        i_CmdKey       = 7'(k);
        i_CmdPhaseStep = 16'(step);
        t_acc          = cyc;
        @(posedge clk);
        #1 i_CmdValid = 1'b0;
    endtask

    // Runs a command the model has already been told about, then checks the end state
    task automatic run_cmd(input bit on, input int k, input int step);
        int n = 0;
        issue(on, k, step);
        @(negedge clk);
        while (!o_CmdReady && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!o_CmdReady) chk("done_timeout", 32'd0, 32'd1);
        lat = cyc - t_acc;
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("drop_count", drop_cnt, {31'd0, exp_drop});
        chk("voice_active", o_VoiceActive, m_act);
    endtask

    task automatic do_cmd(input bit on, input int k, input int step);
        model_cmd(on, k, step);
        run_cmd(on, k, step);
    endtask

    initial begin
        i_Reset        = 1'b1;
        i_CmdValid     = 1'b0;
        i_CmdNoteOn    = 1'b0;
        i_CmdKey       = '0;
        i_CmdPhaseStep = '0;
        i_WriteReady   = 1'b1;
        wr_count       = 0;
        first_wr_cyc   = -1;
        drop_cnt       = 0;
        drop_cyc       = -1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, o_CmdReady}, 32'd1);
        chk("rst_write_valid", {31'd0, o_WriteValid}, 32'd0);
        chk("rst_voice_active", o_VoiceActive, 32'd0);
        chk("rst_drop", {31'd0, o_Drop}, 32'd0);
        chk("rst_dbg_state", {29'd0, o_DbgState}, 32'd0);

        // Free-voice note-on, key 60
        model_cmd(1, 60, 16'h0400);
        chk("model_on_count", exp_q.size(), 32'd9);
        chk("model_on_first", {1'b0, exp_q[0]}, {1'b0, 15'h0000, 16'h0400});
        chk("model_on_last", {1'b0, exp_q[8]}, {1'b0, 15'h1000, 16'h0001});
        run_cmd(1, 60, 16'h0400);
        chk("on_first_write_lat", first_wr_cyc - t_acc, 32'd33);
        chk("on_ready_lat", lat, 32'd42);
        chk("on_active_lit", o_VoiceActive, 32'h0000_0001);
        chk("on_write_count", wr_count, 32'd9);

        // Second voice, then note-off 60
        do_cmd(1, 62, 16'h0123);
        chk("on62_active_lit", o_VoiceActive, 32'h0000_0003);
        model_cmd(0, 60, 0);
        chk("model_off_count", exp_q.size(), 32'd1);
        chk("model_off_write", {1'b0, exp_q[0]}, {1'b0, 15'h1000, 16'h0000});
        run_cmd(0, 60, 0);
        chk("off_ready_lat", lat, 32'd34);
        chk("off_write_lat", first_wr_cyc - t_acc, 32'd33);
        chk("off_active_lit", o_VoiceActive, 32'h0000_0002);

        // Note-off miss with nothing active
        do_cmd(0, 62, 0);
        do_cmd(0, 99, 0);
        chk("miss_drop_lat", drop_cyc - t_acc, 32'd33);
        chk("miss_no_write", wr_count, 32'd0);
        chk("miss_first_valid", first_wr_cyc, 32'hffffffff);
        chk("miss_ready_lat", lat, 32'd34);

        // Retrigger costs one extra cycle
        do_cmd(1, 70, 16'h0777);
        do_cmd(1, 70, 16'h0778);
        chk("retrig_ready_lat", lat, 32'd43);
        chk("retrig_write_count", wr_count, 32'd10);
        do_cmd(0, 70, 0);

        // Stalled note-on
        rand_ready = 1;
        do_cmd(1, 33, 16'hbeef);
        chk("stall_write_count", wr_count, 32'd9);
        rand_ready = 0;

        // 33 distinct note-ons
        do_reset();
        for (int i = 0; i < 32; i++) do_cmd(1, i + 10, i * 3 + 1);
        chk("full_active_lit", o_VoiceActive, 32'hffff_ffff);
        model_cmd(1, 100, 16'h0abc);
`ifdef VOICE_STEAL_EN
        chk("model_steal_count", exp_q.size(), 32'd10);
        chk("model_steal_off", {1'b0, exp_q[0]}, {1'b0, 15'h1000, 16'h0000});
        chk("model_steal_phase", {1'b0, exp_q[1]}, {1'b0, 15'h0000, 16'h0abc});
        run_cmd(1, 100, 16'h0abc);
        chk("steal_ready_lat", lat, 32'd43);
`else
        chk("model_full_count", exp_q.size(), 32'd0);
        run_cmd(1, 100, 16'h0abc);
        chk("full_drop_lat", drop_cyc - t_acc, 32'd33);
        chk("full_no_write", wr_count, 32'd0);
`endif
        chk("full_active_after", o_VoiceActive, 32'hffff_ffff);

        // Random commands with random write stalls
        do_reset();
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            do_cmd(1'($urandom_range(0, 2) != 0), $urandom_range(0, 9), $urandom_range(0, 16'hffff));
        end
        rand_ready = 0;

        // Reset after the third phase write
        do_reset();
        model_cmd(1, 20, 16'h1234);
        issue(1, 20, 16'h1234);
        begin
            int n = 0;
            while (wr_count < 3 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("third_write_seen", wr_count, 32'd3);
        end
        @(posedge clk);
        #1 i_Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_write_valid", {31'd0, o_WriteValid}, 32'd0);
        chk("abort_voice_active", o_VoiceActive, 32'd0);
        @(posedge clk);
        #1 i_Reset = 1'b0;
        model_clear();
        model_cmd(1, 21, 16'h0055);
        chk("model_fresh_first", {1'b0, exp_q[0]}, {1'b0, 15'h0000, 16'h0055});
        run_cmd(1, 21, 16'h0055);
        chk("fresh_active_lit", o_VoiceActive, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
